// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if
//   Instruction-memory port bundle between the refill controller and memory.
//   master : refill controller (drives the request, receives the response)
//   slave  : memory side
//   Signals:
//     mem_req_valid  - request valid (held until mem_req_ready)
//     mem_req_addr   - line-aligned request address
//     mem_req_ready  - memory accepts the request
//     mem_resp_valid - one-cycle response strobe, in order, one outstanding
//     mem_resp_data  - LINE_SIZE*32-bit line, word 0 in the LSBs
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface icache_refill_ctrl_if #(
  parameter int unsigned LINE_SIZE = 2
);
  logic                          mem_req_valid;
  logic [`ADDR_WIDTH-1:0]        mem_req_addr;
  logic                          mem_req_ready;
  logic                          mem_resp_valid;
  logic [LINE_SIZE*32-1:0]       mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//   Captures i_cache miss pulses from its two read ports into two pending
//   slots (duplicates removed), fetches the lines from memory one at a time in
//   port order and returns each line to i_cache as a one-cycle refill strobe.
//   A pipeline flush clears pending misses; a response already in flight is
//   drained and discarded.
//   Ports:
//     clk, reset       - clock, asynchronous active-low reset
//     ext_flush        - synchronous pipeline flush
//     req_valid[1:0]   - miss pulses from i_cache read ports
//     req_addr[2]      - miss addresses
//     mem              - memory request/response bundle (master side)
//     fetch_addr       - refill line address (registered, holds value)
//     fetch_addr_valid - one-cycle refill strobe
//     fetched_data     - refill line data (registered, holds value)
//     busy             - FSM not idle or a slot pending
//     req_drop         - sticky: a miss arrived while not idle
//     refill_count     - refills delivered, wraps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module icache_refill_ctrl #(
  parameter int unsigned LINE_SIZE = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ext_flush,
  input  logic [1:0]                   req_valid,
  input  logic [`ADDR_WIDTH-1:0]       req_addr [2],
  icache_refill_ctrl_if.master         mem,
  output logic [`ADDR_WIDTH-1:0]       fetch_addr,
  output logic                         fetch_addr_valid,
  output logic [LINE_SIZE*32-1:0]      fetched_data,
  output logic                         busy,
  output logic                         req_drop,
  output logic [31:0]                  refill_count
);

  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned LO = $clog2(LINE_SIZE) + 2;
  localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << LO) - AW'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t          state;
  logic [1:0]      s_valid;
  logic [AW-1:0]   s_addr [2];

  logic [AW-1:0]   line0;
  logic [AW-1:0]   line1;
  logic            same_line;

  assign line0     = req_addr[0] & LINE_MASK;
  assign line1     = req_addr[1] & LINE_MASK;
  assign same_line = (line0 == line1);

  assign busy = (state != IDLE) || (|s_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      s_valid           <= '0;
      s_addr[0]         <= '0;
      s_addr[1]         <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_addr  <= '0;
      fetch_addr        <= '0;
      fetch_addr_valid  <= 1'b0;
      fetched_data      <= '0;
      req_drop          <= 1'b0;
      refill_count      <= '0;
    end else begin
      fetch_addr_valid <= 1'b0;

      if (state != IDLE && req_valid != 2'b00) begin
        req_drop <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!ext_flush) begin
            if (req_valid[0]) begin
              s_valid[0]        <= 1'b1;
              s_addr[0]         <= line0;
              if (req_valid[1] && !same_line) begin
                s_valid[1] <= 1'b1;
                s_addr[1]  <= line1;
              end
              mem.mem_req_valid <= 1'b1;
              mem.mem_req_addr  <= line0;
              state             <= ISSUE;
            end else if (req_valid[1]) begin
              s_valid[0]        <= 1'b1;
              s_addr[0]         <= line1;
              mem.mem_req_valid <= 1'b1;
              mem.mem_req_addr  <= line1;
              state             <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= ext_flush ? DRAIN : WAIT;
          end else if (ext_flush) begin
            mem.mem_req_valid <= 1'b0;
            state             <= IDLE;
          end
        end

        WAIT: begin
          if (mem.mem_resp_valid) begin
            if (!ext_flush) begin
              fetch_addr       <= s_addr[0];
              fetch_addr_valid <= 1'b1;
              fetched_data     <= mem.mem_resp_data;
              refill_count     <= refill_count + 32'd1;
              s_valid[0]       <= s_valid[1];
              s_addr[0]        <= s_addr[1];
              s_valid[1]       <= 1'b0;
              if (s_valid[1]) begin
                mem.mem_req_valid <= 1'b1;
                mem.mem_req_addr  <= s_addr[1];
                state             <= ISSUE;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= IDLE;
            end
          end else if (ext_flush) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          // The awaited response retires the drain even under a concurrent
          // flush; otherwise nothing would ever release DRAIN.
          if (mem.mem_resp_valid) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Flush overrides any slot update made above.
      if (ext_flush) begin
        s_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_icache_refill_ctrl;
  localparam int unsigned LINE_SIZE  = 2;
  localparam int unsigned AW         = `ADDR_WIDTH;
  localparam int unsigned DW         = LINE_SIZE * 32;
  localparam int unsigned LINE_BYTES = LINE_SIZE * 4;
  localparam int unsigned CW         = (DW > AW) ? ((DW > 32) ? DW : 32) : ((AW > 32) ? AW : 32);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            ext_flush = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [AW-1:0]   req_addr [2];
  logic [AW-1:0]   fetch_addr;
  logic            fetch_addr_valid;
  logic [DW-1:0]   fetched_data;
  logic            busy;
  logic            req_drop;
  logic [31:0]     refill_count;

  icache_refill_ctrl_if #(.LINE_SIZE(LINE_SIZE)) mem_if ();

  icache_refill_ctrl #(.LINE_SIZE(LINE_SIZE)) dut (
    .clk              (clk),
    .reset            (reset),
    .ext_flush        (ext_flush),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .mem              (mem_if),
    .fetch_addr       (fetch_addr),
    .fetch_addr_valid (fetch_addr_valid),
    .fetched_data     (fetched_data),
    .busy             (busy),
    .req_drop         (req_drop),
    .refill_count     (refill_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: refills delivered and the sticky drop flag.
  int unsigned exp_count = 0;
  bit          exp_drop  = 1'b0;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a - AW'(a % LINE_BYTES);
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < int'(LINE_SIZE); k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset_checks(input string tag);
    chk({tag, "_mreq_valid"}, CW'(mem_if.mem_req_valid), CW'(0));
    chk({tag, "_mreq_addr"},  CW'(mem_if.mem_req_addr),  CW'(0));
    chk({tag, "_fetch_addr"}, CW'(fetch_addr),           CW'(0));
    chk({tag, "_fetch_vld"},  CW'(fetch_addr_valid),     CW'(0));
    chk({tag, "_fetch_data"}, CW'(fetched_data),         CW'(0));
    chk({tag, "_busy"},       CW'(busy),                 CW'(0));
    chk({tag, "_drop"},       CW'(req_drop),             CW'(0));
    chk({tag, "_count"},      CW'(refill_count),         CW'(0));
  endtask

  // One miss episode from IDLE: expected fetches derived from the capture
  // rules, memory answers after 'stall' not-ready cycles and 'lat' wait cycles.
  task automatic do_episode(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input int unsigned stall, input int unsigned lat,
                            input logic [DW-1:0] d0, input bit poke);
    logic [AW-1:0] exp_q [$];
    logic [DW-1:0] d;
    if (v[0]) exp_q.push_back(line_of(a0));
    if (v[1] && !(v[0] && line_of(a1) == line_of(a0))) exp_q.push_back(line_of(a1));

    req_valid   = v;
    req_addr[0] = a0;
    req_addr[1] = a1;
    step();
    req_valid = 2'b00;

    foreach (exp_q[i]) begin
      d = (i == 0) ? d0 : ~d0;
      chk("mreq_valid", CW'(mem_if.mem_req_valid), CW'(1));
      chk("mreq_addr",  CW'(mem_if.mem_req_addr),  CW'(exp_q[i]));
      chk("busy_active", CW'(busy), CW'(1));
      for (int unsigned s = 0; s < stall; s++) begin
        step();
        chk("hold_valid", CW'(mem_if.mem_req_valid), CW'(1));
        chk("hold_addr",  CW'(mem_if.mem_req_addr),  CW'(exp_q[i]));
      end
      mem_if.mem_req_ready = 1'b1;
      step();
      mem_if.mem_req_ready = 1'b0;
      chk("mreq_low_after_hs", CW'(mem_if.mem_req_valid), CW'(0));
      for (int unsigned w = 0; w < lat; w++) begin
        if (poke && w == 0) begin
          req_valid = 2'($urandom_range(1, 3));
          exp_drop  = 1'b1;
        end
        step();
        req_valid = 2'b00;
        chk("no_early_refill", CW'(fetch_addr_valid), CW'(0));
      end
      mem_if.mem_resp_valid = 1'b1;
      mem_if.mem_resp_data  = d;
      step();
      mem_if.mem_resp_valid = 1'b0;
      exp_count++;
      chk("refill_strobe", CW'(fetch_addr_valid), CW'(1));
      chk("fetch_addr",    CW'(fetch_addr),       CW'(exp_q[i]));
      chk("fetched_data",  CW'(fetched_data),     CW'(d));
      chk("refill_count",  CW'(refill_count),     CW'(exp_count));
      chk("req_drop",      CW'(req_drop),         CW'(exp_drop));
    end
    chk("busy_done",  CW'(busy), CW'(0));
    chk("mreq_idle",  CW'(mem_if.mem_req_valid), CW'(0));
    step();
    chk("strobe_one_cycle", CW'(fetch_addr_valid), CW'(0));
    chk("fetch_addr_hold",  CW'(fetch_addr), CW'(exp_q[exp_q.size()-1]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a0, a1;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data  = '0;
    req_addr[0] = '0;
    req_addr[1] = '0;

    step();
    step();
    do_reset_checks("reset");
    reset = 1'b1;
    step();

    // Flush in IDLE: requests ignored, no drop.
    req_valid = 2'b11; req_addr[0] = 32'h0000_0100; req_addr[1] = 32'h0000_0200;
    ext_flush = 1'b1;
    step();
    req_valid = 2'b00; ext_flush = 1'b0;
    chk("fl_idle_mreq", CW'(mem_if.mem_req_valid), CW'(0));
    chk("fl_idle_busy", CW'(busy), CW'(0));
    chk("fl_idle_drop", CW'(req_drop), CW'(0));

    // Flush in ISSUE without handshake.
    req_valid = 2'b01; req_addr[0] = 32'h0000_0300;
    step();
    req_valid = 2'b00;
    chk("fl_issue_pre", CW'(mem_if.mem_req_valid), CW'(1));
    ext_flush = 1'b1;
    step();
    ext_flush = 1'b0;
    chk("fl_issue_mreq", CW'(mem_if.mem_req_valid), CW'(0));
    chk("fl_issue_busy", CW'(busy), CW'(0));

    // Flush in ISSUE together with the handshake: drain.
    req_valid = 2'b11; req_addr[0] = 32'h0000_0400; req_addr[1] = 32'h0000_0500;
    step();
    req_valid = 2'b00;
    ext_flush = 1'b1; mem_if.mem_req_ready = 1'b1;
    step();
    ext_flush = 1'b0; mem_if.mem_req_ready = 1'b0;
    chk("fl_hs_mreq", CW'(mem_if.mem_req_valid), CW'(0));
    chk("fl_hs_busy", CW'(busy), CW'(1));
    step();
    chk("fl_hs_busy2", CW'(busy), CW'(1));
    mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_data = rand_line();
    step();
    mem_if.mem_resp_valid = 1'b0;
    chk("fl_hs_nostrobe", CW'(fetch_addr_valid), CW'(0));
    chk("fl_hs_busy_end", CW'(busy), CW'(0));
    chk("fl_hs_count", CW'(refill_count), CW'(exp_count));
    chk("fl_hs_mreq_end", CW'(mem_if.mem_req_valid), CW'(0));

    // Flush in WAIT, response 4 cycles later; second slot must be lost too.
    req_valid = 2'b11; req_addr[0] = 32'h0000_0600; req_addr[1] = 32'h0000_0704;
    step();
    req_valid = 2'b00;
    mem_if.mem_req_ready = 1'b1;
    step();
    mem_if.mem_req_ready = 1'b0;
    ext_flush = 1'b1;
    step();
    ext_flush = 1'b0;
    chk("fl_wait_drain", CW'(busy), CW'(1));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_wait_nostrobe", CW'(fetch_addr_valid), CW'(0));
      chk("fl_wait_mreq", CW'(mem_if.mem_req_valid), CW'(0));
    end
    mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_data = rand_line();
    step();
    mem_if.mem_resp_valid = 1'b0;
    chk("fl_wait_nostrobe_r", CW'(fetch_addr_valid), CW'(0));
    chk("fl_wait_idle", CW'(busy), CW'(0));
    chk("fl_wait_count", CW'(refill_count), CW'(exp_count));
    chk("fl_wait_mreq_end", CW'(mem_if.mem_req_valid), CW'(0));

    // Flush in WAIT with the response in the same cycle.
    req_valid = 2'b01; req_addr[0] = 32'h0000_0800;
    step();
    req_valid = 2'b00;
    mem_if.mem_req_ready = 1'b1;
    step();
    mem_if.mem_req_ready = 1'b0;
    ext_flush = 1'b1; mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_data = rand_line();
    step();
    ext_flush = 1'b0; mem_if.mem_resp_valid = 1'b0;
    chk("fl_resp_nostrobe", CW'(fetch_addr_valid), CW'(0));
    chk("fl_resp_idle", CW'(busy), CW'(0));
    chk("fl_resp_count", CW'(refill_count), CW'(exp_count));
    chk("fl_drop_clear", CW'(req_drop), CW'(0));

    // Directed scenarios.
    do_episode(2'b01, 32'h0000_1004, 32'h0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    do_episode(2'b11, 32'h0000_2000, 32'h0000_3004, 0, 0, rand_line(), 1'b0);
    do_episode(2'b11, 32'h0000_4000, 32'h0000_4004, 0, 1, rand_line(), 1'b0);
    do_episode(2'b10, 32'h0, 32'h0000_4C0C, 0, 0, rand_line(), 1'b0);
    do_episode(2'b01, 32'h0000_5008, 32'h0, 5, 2, rand_line(), 1'b0);

    // Randomized episodes.
    for (int n = 0; n < 40; n++) begin
      a0 = $urandom;
      a1 = ($urandom_range(0, 1) == 1) ? (a0 ^ AW'($urandom_range(0, LINE_BYTES - 1))) : AW'($urandom);
      do_episode(2'($urandom_range(1, 3)), a0, a1, $urandom_range(0, 3), $urandom_range(0, 3),
                 rand_line(), ($urandom_range(0, 3) == 0));
    end

    // Guaranteed drop, then async reset mid-ISSUE.
    do_episode(2'b01, 32'h0000_6000, 32'h0, 0, 2, rand_line(), 1'b1);
    chk("drop_sticky", CW'(req_drop), CW'(1));
    req_valid = 2'b01; req_addr[0] = 32'h0000_7000;
    step();
    req_valid = 2'b00;
    chk("rst_pre_issue", CW'(mem_if.mem_req_valid), CW'(1));
    #2;
    reset = 1'b0;
    #1;
    do_reset_checks("async_rst");
    step();
    reset = 1'b1;
    exp_count = 0;
    exp_drop  = 1'b0;
    step();
    do_episode(2'b11, 32'h0000_8000, 32'h0000_9000, 1, 1, rand_line(), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Refill controller between `i_cache` and the instruction memory port. Captures the one-cycle miss requests `i_cache` raises on its two read ports, removes duplicates, and issues line fetches to memory one at a time in port order. Each returned line goes back to `i_cache` on its `fetch_addr`/`fetch_addr_valid`/`fetched_data` refill inputs. Handles pipeline flushes by draining any response already in flight.

## Interface
- `LINE_SIZE`, default 2: 32-bit words per cache line; must match `i_cache`. Line offset bits `LO = $clog2(LINE_SIZE)+2`.
- Address width is `` `ADDR_WIDTH `` from `riscv_core.svh`; it is not a parameter.
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `ext_flush`, in, 1: synchronous pipeline flush.
- `req_valid[2]`, in, 1 each: miss pulses, wired from `i_cache.request_valid`.
- `req_addr[2]`, in, `` `ADDR_WIDTH `` each: miss addresses, wired from `i_cache.request_addr`.
- `mem_req_valid`, out, 1: memory request valid.
- `mem_req_addr`, out, `` `ADDR_WIDTH ``: line-aligned address, low `LO` bits are 0.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_resp_valid`, in, 1: one-cycle response strobe. Memory answers in order, at most one outstanding.
- `mem_resp_data`, in, `LINE_SIZE*32`: line data; word 0 is in the LSBs.
- `fetch_addr`, out, `` `ADDR_WIDTH ``: refill address to `i_cache`.
- `fetch_addr_valid`, out, 1: one-cycle refill strobe.
- `fetched_data`, out, `LINE_SIZE*32`: refill data to `i_cache`.
- `busy`, out, 1: high when state is not IDLE or any slot is valid.
- `req_drop`, out, 1: sticky flag; set when a request arrives and cannot be captured. Cleared only by reset.
- `refill_count`, out, 32: number of refills delivered; wraps at 2^32.

## Operation
- **Pending slots.** Two slots, S0 and S1. Each holds a valid bit and a line address.
  - Line address = `req_addr & ~((1<<LO)-1)`.
- **Capture (IDLE only).**
  - `req_valid[0]` is loaded into S0, then `req_valid[1]` into the next free slot.
  - If both ports are valid with the same line address, only S0 is loaded.
  - If only port 1 is valid, it goes to S0.
  - A `req_valid` in any state other than IDLE is ignored and sets `req_drop`.
- **FSM states:** IDLE, ISSUE, WAIT, DRAIN.
  - IDLE → ISSUE when a capture loads at least one slot.
  - ISSUE: `mem_req_valid=1`, `mem_req_addr=S0.addr`. Held stable until `mem_req_ready`; the handshake moves to WAIT.
  - WAIT, on `mem_resp_valid`:
    - Register the refill: `fetch_addr=S0.addr`, `fetch_addr_valid=1` next cycle, `fetched_data=mem_resp_data`. Increment `refill_count`.
    - Shift S1 into S0 and invalidate S1.
    - Go to ISSUE if the shifted S0 is valid, else IDLE.
  - DRAIN: wait for `mem_resp_valid`, discard it (no refill strobe, no count), then go to IDLE.
- **Flush** (`ext_flush=1` in cycle F, reset excepted): clear both slots.
  - IDLE: stay IDLE. Requests arriving in cycle F are not captured and do not set `req_drop`.
  - ISSUE without handshake in F: go to IDLE and deassert `mem_req_valid` in F+1.
  - ISSUE with handshake in F: go to DRAIN.
  - WAIT with no response in F: go to DRAIN.
  - WAIT with response in F: the response is discarded and the FSM goes to IDLE.
  - DRAIN: stay in DRAIN.
  - A refill strobe already registered for cycle F+1 is suppressed.
- **Reset (asserted at any time):** state=IDLE, slots invalid, every output 0, including `req_drop` and `refill_count`. A memory response still in flight after reset is the memory side's responsibility.

## Timing
- Capture in cycle N (IDLE): `mem_req_valid=1` in N+1.
- Handshake in cycle H: state=WAIT in H+1. `mem_req_valid=0` from H+1.
- Response in cycle R: `fetch_addr_valid=1` in R+1, for exactly one cycle.
  - If a second slot is pending, `mem_req_valid=1` for that line in R+1.
- Minimum miss-to-refill latency is 3 cycles: N capture, N+1 handshake, N+2 response, N+3 refill.
- `busy` is registered-state derived; it is 1 from N+1 until the cycle after the last refill or drain.
- `fetch_addr` and `fetched_data` are registered and keep their last values when `fetch_addr_valid=0`.

## Test plan
- **Single miss.** Reset, then `req_valid={1,0}`, `req_addr[0]=0x1004`; ready tied 1, response 1 cycle after the handshake with data `0xAAAA_BBBB_CCCC_DDDD` → `mem_req_addr=0x1000` one cycle after the pulse. `fetch_addr=0x1000`, `fetched_data=0xAAAA_BBBB_CCCC_DDDD`, a single `fetch_addr_valid` pulse 3 cycles after the pulse. `refill_count=1`, `busy` returns to 0.
- **Dual miss, distinct lines.** `req_addr={0x2000,0x3004}` → two memory requests in order, 0x2000 then 0x3000. Two refill strobes; the second memory request is asserted in the same cycle as the first refill strobe.
- **Dual miss, same line.** `req_addr={0x4000,0x4004}` → exactly one memory request (0x4000), one refill, `refill_count` +1.
- **Backpressure.** `mem_req_ready=0` for 5 cycles → `mem_req_valid` and `mem_req_addr` held constant for 5 cycles; WAIT is entered only after `ready=1`.
- **Flush in WAIT.** `ext_flush` the cycle after the handshake, response 4 cycles later → state DRAIN, no `fetch_addr_valid`, `refill_count` unchanged, IDLE the cycle after the response. A new miss issued afterwards is serviced normally.
- **Drop and reset.** A `req_valid` pulse while in WAIT → `req_drop=1` and stays 1. Async reset mid-ISSUE → all outputs 0 immediately, `req_drop=0`.
